switch_debounce: RTL

- Input conditioner that sits directly upstream of the 8-bit switch-reader PIO.
- Synchronises raw board switch pins into the clk domain, then debounces each bit independently.
- Drives a glitch-free switch bus into the PIO in_port, plus change-event strobes.
- Optional sticky edge-capture register for software polling.

---
 rtl/switch_debounce.sv | 135 +++++++++++++
 1 files changed

// File: rtl/switch_debounce.sv
// rtl/switch_debounce.sv - two-flop synchroniser and per-bit debouncer for the switch-reader PIO input
//
// Parameters:
//   WIDTH            number of switch bits conditioned
//   DEBOUNCE_CYCLES  consecutive cycles a synchronised bit must differ from
//                    the stable value before it is accepted (1 .. 2^CNT_WIDTH-1)
//   CNT_WIDTH        width of each per-bit debounce counter
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous active-high reset
//   sw_raw        raw switch pins, asynchronous to clk
//   sw_out        debounced switch value (drives the PIO in_port)
//   change_mask   one-cycle strobe per bit in the cycle sw_out[i] updates
//   change_pulse  OR of change_mask, same cycle
//   settled       high when no bit has a pending transition
//   edge_clear    write-one-to-clear for edge_capture
//   edge_capture  sticky rising-edge flags
//
// Optional feature macro: SWITCH_DEBOUNCE_EDGE_CAPTURE_EN
//   defined   : edge_capture holds sticky 0->1 flags of sw_out, cleared by
//               edge_clear; a set and a clear in the same cycle keeps the flag.
//   undefined : edge_capture is tied to 0 and edge_clear is ignored.

module switch_debounce #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_WIDTH       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_out,
  output logic [WIDTH-1:0] change_mask,
  output logic             change_pulse,
  output logic             settled,
  input  logic [WIDTH-1:0] edge_clear,
  output logic [WIDTH-1:0] edge_capture
);

  // Counter value on which the pending value is accepted. The counter
  // therefore never exceeds DEBOUNCE_CYCLES-1 and cannot wrap.
  localparam logic [CNT_WIDTH-1:0] CNT_TERM = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  // Synchroniser chain; sync1 is the only flop that samples sw_raw.
  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;

  // Per-bit debounce counters.
  logic [CNT_WIDTH-1:0] cnt     [WIDTH];
  logic [CNT_WIDTH-1:0] cnt_nxt [WIDTH];

  // Next-state values for the registered outputs.
  logic [WIDTH-1:0] sw_nxt;
  logic [WIDTH-1:0] mask_nxt;
  logic             settled_nxt;

  // Per-bit debounce decision. A bit that matches the stable value drops
  // its count, so any glitch shorter than DEBOUNCE_CYCLES is forgotten.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      cnt_nxt[i]  = '0;
      sw_nxt[i]   = sw_out[i];
      mask_nxt[i] = 1'b0;
      if (sync2[i] != sw_out[i]) begin
        if (cnt[i] == CNT_TERM) begin
          sw_nxt[i]   = sync2[i];
          mask_nxt[i] = 1'b1;
        end else begin
          cnt_nxt[i] = cnt[i] + CNT_WIDTH'(1);
        end
      end
    end
  end

  // settled looks at the next-state counters so it lines up with sw_out:
  // it rises in the same cycle the last pending bit is accepted.
  always_comb begin
    settled_nxt = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      if (cnt_nxt[i] != '0) begin
        settled_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1        <= '0;
      sync2        <= '0;
      sw_out       <= '0;
      change_mask  <= '0;
      change_pulse <= 1'b0;
      settled      <= 1'b1;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1        <= sw_raw;
      sync2        <= sync1;
      sw_out       <= sw_nxt;
      change_mask  <= mask_nxt;
      change_pulse <= |mask_nxt;
      settled      <= settled_nxt;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
    end
  end

`ifdef SWITCH_DEBOUNCE_EDGE_CAPTURE_EN
  // Sticky rising-edge flags. The set term is ORed in after the clear so a
  // rise that coincides with a clear is still recorded.
  logic [WIDTH-1:0] capture_q;
  logic [WIDTH-1:0] rise_nxt;

  assign rise_nxt = mask_nxt & sw_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      capture_q <= '0;
    end else begin
      capture_q <= rise_nxt | (capture_q & ~edge_clear);
    end
  end

  assign edge_capture = capture_q;
`else
  // Feature disabled: ports stay in place, no capture flops exist.
  logic unused_edge_clear;
  assign unused_edge_clear = ^edge_clear;
  assign edge_capture      = '0;
`endif

endmodule
